// File: rtl/counter_pkg.sv
// Shared definitions for the counter library: end-of-range mode encodings
// and the one-shot FSM state type.
package counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'd0;
    localparam logic [1:0] MODE_SAT     = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_e;

endpackage

// File: rtl/mod_step.sv
// Combinational modulo-MOD step: the next value one position up or down,
// plus terminal-count and wrap flags for the current value and direction.
module mod_step
    import counter_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter longint unsigned MOD   = 256
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] next_o,
    output logic             tc_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 64'd1);

    always_comb begin
        tc_o   = up_i ? (val_i == MAX_VAL) : (val_i == '0);
        wrap_o = tc_o;
        if (up_i) begin
            next_o = tc_o ? '0 : val_i + WIDTH'(1);
        end else begin
            next_o = tc_o ? MAX_VAL : val_i - WIDTH'(1);
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down modulus counter with wrap, saturate and one-shot end-of-range modes,
// synchronous clear/load, and status flags for downstream sequencing logic.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter longint unsigned MOD   = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap,
    output logic             ovf,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 64'd1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    state_e           state_q, state_d;

    logic [WIDTH-1:0] step_next;
    logic             step_tc;
    logic             step_wrap;

    mod_step #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_step (
        .val_i  (out_q),
        .up_i   (up),
        .next_o (step_next),
        .tc_o   (step_tc),
        .wrap_o (step_wrap)
    );

    always_comb begin
        out_d   = out_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        state_d = state_q;

        if (clr) begin
            out_d   = '0;
            ovf_d   = 1'b0;
            state_d = RUN;
        end else if (load) begin
            out_d   = (64'(load_val) >= MOD) ? MAX_VAL : load_val;
            ovf_d   = 1'b0;
            state_d = RUN;
        end else if (count) begin
            case (mode)
                MODE_SAT: begin
                    if (step_tc) ovf_d = 1'b1;
                    else         out_d = step_next;
                end
                MODE_ONESHOT: begin
                    // Once DONE, further steps only record the overrun.
                    if (state_q == DONE) ovf_d   = 1'b1;
                    else if (step_tc)    state_d = DONE;
                    else                 out_d   = step_next;
                end
                default: begin
                    out_d  = step_next;
                    wrap_d = step_wrap;
                end
            endcase
        end

        // Leaving one-shot mode (or never being in it) parks the FSM in RUN.
        if (mode != MODE_ONESHOT) state_d = RUN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q   <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= RUN;
        end else begin
            out_q   <= out_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

    assign out  = out_q;
    assign tc   = step_tc;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed-vector and reference-model bench for mod_updown_counter (WIDTH=4, MOD=10).
module tb_mod_updown_counter;

    localparam int              W = 4;
    localparam longint unsigned M = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         count = 1'b0;
    logic         up = 1'b0;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [1:0]   mode = 2'd0;
    logic [W-1:0] out;
    logic         tc;
    logic         wrap;
    logic         ovf;
    logic         done;

    int errors = 0;
    int checks = 0;

    mod_updown_counter #(
        .WIDTH (W),
        .MOD   (M)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .count    (count),
        .up       (up),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .out      (out),
        .tc       (tc),
        .wrap     (wrap),
        .ovf      (ovf),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       c, u, cl, ld;
        logic [3:0] lv;
        logic [1:0] md;
        logic [3:0] eo;
        logic       etc, ew, eov, ed;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic u, input logic cl, input logic ld,
                       input logic [3:0] lv, input logic [1:0] md, input logic [3:0] eo,
                       input logic etc, input logic ew, input logic eov, input logic ed);
        vec_t v;
        v.c = c; v.u = u; v.cl = cl; v.ld = ld; v.lv = lv; v.md = md;
        v.eo = eo; v.etc = etc; v.ew = ew; v.eov = eov; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic c, input logic u, input logic cl, input logic ld,
                         input logic [3:0] lv, input logic [1:0] md);
        @(negedge clk);
        count = c; up = u; clr = cl; load = ld; load_val = lv; mode = md;
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    int m_o, m_ovf, m_done, m_wrap;

    task automatic model_edge();
        int at_lim;
        m_wrap = 0;
        at_lim = up ? (m_o == 9) : (m_o == 0);
        if (clr) begin
            m_o = 0; m_ovf = 0; m_done = 0;
        end else if (load) begin
            m_o = (load_val > 9) ? 9 : int'(load_val);
            m_ovf = 0; m_done = 0;
        end else if (count) begin
            if (mode == 2'd1) begin
                if (at_lim != 0) m_ovf = 1;
                else m_o = up ? m_o + 1 : m_o - 1;
            end else if (mode == 2'd2) begin
                if (m_done != 0) m_ovf = 1;
                else if (at_lim != 0) m_done = 1;
                else m_o = up ? m_o + 1 : m_o - 1;
            end else begin
                if (at_lim != 0) begin
                    m_o = up ? 0 : 9;
                    m_wrap = 1;
                end else begin
                    m_o = up ? m_o + 1 : m_o - 1;
                end
            end
        end
        if (mode != 2'd2) m_done = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        // Up-count wrap sequence
        for (int i = 1; i <= 9; i++) add(1, 1, 0, 0, 0, 0, 4'(i), (i == 9), 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // Load with count, then count down through 0
        add(1, 0, 0, 1, 3, 0, 3, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 9, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0);
        // Saturate
        add(0, 1, 0, 1, 8, 1, 8, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 1, 9, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 1, 9, 1, 0, 1, 0);
        add(1, 1, 0, 0, 0, 1, 9, 1, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 9, 1, 0, 1, 0);
        add(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        // One-shot
        add(0, 1, 0, 1, 7, 2, 7, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 2, 8, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 2, 9, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 2, 9, 1, 0, 0, 1);
        add(1, 1, 0, 0, 0, 2, 9, 1, 0, 1, 1);
        add(0, 1, 0, 1, 2, 2, 2, 0, 0, 0, 0);
        add(0, 1, 0, 1, 9, 2, 9, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 2, 9, 1, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        // Reserved mode acts as wrap
        add(1, 1, 0, 0, 0, 3, 0, 0, 1, 0, 0);
        // Clamp, clr beats load, saturate at 0 going down
        add(0, 1, 0, 1, 15, 0, 9, 1, 0, 0, 0);
        add(0, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0);
        add(1, 1, 0, 1, 4, 1, 4, 0, 0, 0, 0);

        // Reset state
        #1;
        chk("reset_out", out, 0);
        chk("reset_wrap", wrap, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_done", done, 0);
        chk("reset_tc_down", tc, 1);
        up = 1'b1;
        #1;
        chk("reset_tc_up", tc, 0);
        count = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_hold_out", out, 0);
        @(negedge clk);
        reset = 1'b1;
        count = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].c, vecs[i].u, vecs[i].cl, vecs[i].ld, vecs[i].lv, vecs[i].md);
            $display("vec %0d: out=%0d tc=%0d wrap=%0d ovf=%0d done=%0d", i, out, tc, wrap, ovf, done);
            chk($sformatf("vec%0d_out", i), out, vecs[i].eo);
            chk($sformatf("vec%0d_tc", i), tc, vecs[i].etc);
            chk($sformatf("vec%0d_wrap", i), wrap, vecs[i].ew);
            chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].eov);
            chk($sformatf("vec%0d_done", i), done, vecs[i].ed);
        end

        // Continuous up-count in WRAP: one pulse per MOD steps
        drive(0, 1, 1, 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            if (wrap) pulses++;
        end
        $display("wrap run: out=%0d pulses=%0d", out, pulses);
        chk("wrap_run_pulses", pulses, 2);
        chk("wrap_run_out", out, 0);

        // Asynchronous reset mid-count
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0, 0);
        chk("pre_reset_out", out, 5);
        #2;
        reset = 1'b0;
        #1;
        $display("async reset: out=%0d", out);
        chk("async_reset_out", out, 0);
        @(negedge clk);
        reset = 1'b1;
        count = 1'b0;
        @(posedge clk);
        #1;
        chk("post_release_out", out, 0);

        // Randomised cycles against the reference model
        m_o = 0; m_ovf = 0; m_done = 0; m_wrap = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            count = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 4) == 0) up = ~up;
            clr = ($urandom_range(0, 24) == 0);
            load = ($urandom_range(0, 11) == 0);
            load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            model_edge();
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_out", i), out, m_o);
            chk($sformatf("rnd%0d_tc", i), tc, up ? (m_o == 9) : (m_o == 0));
            chk($sformatf("rnd%0d_wrap", i), wrap, m_wrap);
            chk($sformatf("rnd%0d_ovf", i), ovf, m_ovf);
            chk($sformatf("rnd%0d_done", i), done, m_done);
            chk($sformatf("rnd%0d_range", i), (out <= 9), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised up/down modulus counter; the successor to the fixed 4-bit up-counter in the counter library. Adds configurable width and modulus, count direction, synchronous load and clear, and three end-of-range modes: wrap, saturate and one-shot. Status outputs (terminal count, wrap pulse, sticky overflow, done) let sequencing logic and timers in the same design react without decoding the count themselves.

## Interface
- WIDTH, 8, count register width in bits; legal range 2..32.
- MOD, 256, modulus; count range is 0..MOD-1; legal range 2..2^WIDTH.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- count  in  1  count enable; step one position per cycle while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  load value.
- mode  in  2  0 = WRAP, 1 = SATURATE, 2 = ONESHOT, 3 = reserved (behaves as WRAP).
- out  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational: (up && out==MOD-1) || (!up && out==0).
- wrap  out  1  registered one-cycle pulse on a wrap event.
- ovf  out  1  sticky flag for an attempted step past a limit in SATURATE or ONESHOT.
- done  out  1  high while the ONESHOT FSM is in DONE.

## Operation
- Per-edge priority: reset > clr > load > count > hold.
- clr: out=0, ovf=0, FSM to RUN, no wrap pulse.
- load: out=load_val, clamped to MOD-1 if load_val ≥ MOD; ovf=0; FSM to RUN; no wrap pulse.
- Count step at a non-terminal value: out±1, all modes.
- Count step at terminal (tc=1):
  - WRAP: out goes to 0 (up) or MOD-1 (down); wrap=1 next cycle.
  - SATURATE: out holds; ovf set.
  - ONESHOT in RUN: out holds; FSM goes to DONE.
  - ONESHOT in DONE: out holds; ovf set.
- ONESHOT FSM:
  - States: RUN, DONE.
  - RUN→DONE on a count step while tc=1.
  - DONE→RUN only on clr or load.
  - In DONE, count is ignored apart from setting ovf.
  - When mode is not ONESHOT, the FSM is forced to RUN.
- Direction and mode may change on any cycle. They take effect on the same edge and act on the current out. A mode change while in DONE returns the FSM to RUN.
- Arithmetic is modulo MOD only; the result never exceeds MOD-1. With MOD=2^WIDTH the natural binary wrap gives the same result.

## Timing
- Reset values: out=0, wrap=0, ovf=0, done=0, FSM=RUN. tc resets to the value decoded from up, i.e. 1 when up=0.
- Latency: out, wrap, ovf and done update one edge after the qualifying input. tc follows out and up combinationally in the same cycle.
- wrap is high for exactly one cycle per wrap event. With count held high at the terminal in WRAP mode, wrap pulses once every MOD cycles.
- Asserting reset mid-sequence clears every register immediately, without waiting for a clock edge. Release is synchronous to the next clk edge.
- clr and load asserted together: clr wins.
- load together with count: the loaded value is stored, with no step applied that cycle.

## Structure
- Shared package counter_pkg:
  - mode encodings MODE_WRAP, MODE_SAT, MODE_ONESHOT;
  - FSM state typedef (RUN, DONE).
- One sub-module, mod_step. It is purely combinational:
  - inputs: out, up, MOD;
  - outputs: next value, terminal flag, wrap flag.
- The top module holds the registers, priority logic and FSM.

## Test plan
Bench parameters: WIDTH=4, MOD=10.
- Reset held low, then released; count=1, up=1, mode=WRAP for 12 cycles → out is 0,1,…,9,0,1; wrap pulses once, the cycle out returns to 0; tc=1 only while out=9.
- load_val=3, load=1 with count=1; then up=0 for 5 cycles in WRAP → out=3,2,1,0,9,8; wrap pulses once, the cycle out becomes 9.
- mode=SATURATE, load 8, count up for 3 cycles → out=9,9,9; ovf rises the cycle after the first blocked step and stays high until clr.
- mode=ONESHOT, load 7, count up → out=8,9; done=1 one cycle after the step taken at 9; further count leaves out=9 and sets ovf; load 2 → done=0, ovf=0, out=2.
- load_val=15 → out=9 (clamped). clr and load asserted together → out=0. reset asserted mid-count at out=5 → out=0 immediately, before the next edge.
- Random cycles of count, up, load and clr in all modes, checked against a reference model; out never exceeds 9.
